// File: rtl/entropy_grant_arbiter.sv
// Round-robin arbiter handing single buffered QRNG words to NUM_REQ consumers,
// with ack timeout, saturating statistics and a health-alarm lockout.
module entropy_grant_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned RECOVER_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   src_data,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic                health_alarm,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  ack,
    output logic [NUM_REQ-1:0]  grant,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                locked,
    output logic [15:0]         served_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_LOCKOUT,
        ST_FILL,
        ST_ARB,
        ST_OFFER
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    buf_q, buf_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [15:0]          timer_q, timer_d;
    logic [15:0]          rec_q, rec_d;
    logic [15:0]          served_q, served_d;
    logic [15:0]          drop_q, drop_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 src_ready_q, src_ready_d;
    logic                 locked_q, locked_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     next_rr;
    int unsigned          cand;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(rr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign next_rr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        timer_d  = timer_q;
        rec_d    = rec_q;
        served_d = served_q;
        drop_d   = drop_q;

        case (state_q)
            ST_LOCKOUT: begin
                if (health_alarm) begin
                    rec_d = '0;
                end else if (rec_q == 16'(RECOVER_CYC - 1)) begin
                    rec_d   = '0;
                    state_d = ST_FILL;
                end else begin
                    rec_d = rec_q + 16'd1;
                end
            end

            ST_FILL: begin
                if (health_alarm) begin
                    if (src_valid && src_ready_q) begin
                        drop_d = sat_inc(drop_q);
                    end
                    state_d = ST_LOCKOUT;
                end else if (src_valid && src_ready_q) begin
                    buf_d   = src_data;
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (health_alarm) begin
                    drop_d  = sat_inc(drop_q);
                    buf_d   = '0;
                    state_d = ST_LOCKOUT;
                end else if (pick_found) begin
                    gidx_d  = pick_idx;
                    timer_d = 16'd1;
                    state_d = ST_OFFER;
                end
            end

            ST_OFFER: begin
                // A granted ack beats both a coincident alarm and timer expiry.
                if (ack[gidx_q]) begin
                    served_d = sat_inc(served_q);
                    buf_d    = '0;
                    rr_d     = next_rr;
                    state_d  = health_alarm ? ST_LOCKOUT : ST_FILL;
                end else if (health_alarm) begin
                    drop_d  = sat_inc(drop_q);
                    buf_d   = '0;
                    state_d = ST_LOCKOUT;
                end else if (!req[gidx_q]) begin
                    state_d = ST_ARB;
                end else if (timer_q == 16'(ACK_TIMEOUT)) begin
                    drop_d  = sat_inc(drop_q);
                    buf_d   = '0;
                    rr_d    = next_rr;
                    state_d = ST_FILL;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: state_d = ST_LOCKOUT;
        endcase
    end

    // Outputs are registered images of the state being entered.
    always_comb begin
        src_ready_d = (state_d == ST_FILL);
        locked_d    = (state_d == ST_LOCKOUT);
        out_valid_d = (state_d == ST_OFFER);
        grant_d     = '0;
        out_data_d  = '0;
        if (state_d == ST_OFFER) begin
            grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_d;
            out_data_d = buf_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOCKOUT;
            buf_q       <= '0;
            gidx_q      <= '0;
            rr_q        <= '0;
            timer_q     <= '0;
            rec_q       <= '0;
            served_q    <= '0;
            drop_q      <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            src_ready_q <= 1'b0;
            locked_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            gidx_q      <= gidx_d;
            rr_q        <= rr_d;
            timer_q     <= timer_d;
            rec_q       <= rec_d;
            served_q    <= served_d;
            drop_q      <= drop_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            src_ready_q <= src_ready_d;
            locked_q    <= locked_d;
        end
    end

    assign src_ready  = src_ready_q;
    assign locked     = locked_q;
    assign grant      = grant_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign served_cnt = served_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_entropy_grant_arbiter.sv
// Directed bench for entropy_grant_arbiter: recovery, round robin, timeout,
// withdraw, alarm handling and counter saturation with hand-computed values.
module tb_entropy_grant_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        health_alarm;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [63:0] out_data;
    logic        out_valid;
    logic        locked;
    logic [15:0] served_cnt;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [63:0] words [0:4];
    logic [3:0]  rr_grants [0:4];

    entropy_grant_arbiter #(
        .NUM_REQ    (4),
        .DATA_W     (64),
        .ACK_TIMEOUT(255),
        .RECOVER_CYC(1024)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .health_alarm(health_alarm),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .locked      (locked),
        .served_cnt  (served_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Capture one word in FILL, then let ARB issue the grant.
    task automatic offer_word(input logic [63:0] w, input logic [3:0] exp_grant, input string tag);
        src_data  = w;
        src_valid = 1'b1;
        step(1);
        src_valid = 1'b0;
        chk({tag, "_ready_low"}, {63'd0, src_ready}, 64'd0);
        step(1);
        chk({tag, "_grant"}, {60'd0, grant}, {60'd0, exp_grant});
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_data"}, out_data, w);
    endtask

    initial begin
        words[0] = 64'h0123_4567_89AB_CDEF;
        words[1] = 64'hFEDC_BA98_7654_3210;
        words[2] = 64'hA5A5_5A5A_DEAD_BEEF;
        words[3] = 64'h0000_0000_0000_0001;
        words[4] = 64'h8000_0000_0000_0000;
        rr_grants[0] = 4'b0001;
        rr_grants[1] = 4'b0010;
        rr_grants[2] = 4'b0100;
        rr_grants[3] = 4'b1000;
        rr_grants[4] = 4'b0001;

        reset_n      = 1'b0;
        src_data     = '0;
        src_valid    = 1'b0;
        health_alarm = 1'b0;
        req          = '0;
        ack          = '0;
        #12;
        chk("rst_locked", {63'd0, locked}, 64'd1);
        chk("rst_src_ready", {63'd0, src_ready}, 64'd0);
        chk("rst_grant", {60'd0, grant}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_served", {48'd0, served_cnt}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);

        // Recovery from reset: 1024 alarm-free edges.
        reset_n = 1'b1;
        step(1023);
        chk("rec_1023_locked", {63'd0, locked}, 64'd1);
        chk("rec_1023_ready", {63'd0, src_ready}, 64'd0);
        step(1);
        chk("rec_1024_locked", {63'd0, locked}, 64'd0);
        chk("rec_1024_ready", {63'd0, src_ready}, 64'd1);

        // Round robin over all four requesters.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            offer_word(words[i], rr_grants[i], "rr");
            ack = rr_grants[i];
            step(1);
            ack = '0;
            chk("rr_grant_drop", {60'd0, grant}, 64'd0);
            chk("rr_valid_drop", {63'd0, out_valid}, 64'd0);
            chk("rr_served", {48'd0, served_cnt}, 64'(i + 1));
            chk("rr_refill", {63'd0, src_ready}, 64'd1);
        end

        // Timeout: out_valid for exactly 255 cycles, then a drop.
        req = 4'b0100;
        offer_word(64'h1111_2222_3333_4444, 4'b0100, "to");
        step(254);
        chk("to_valid_255", {63'd0, out_valid}, 64'd1);
        chk("to_drop_before", {48'd0, drop_cnt}, 64'd0);
        step(1);
        chk("to_valid_gone", {63'd0, out_valid}, 64'd0);
        chk("to_drop_after", {48'd0, drop_cnt}, 64'd1);
        chk("to_refill", {63'd0, src_ready}, 64'd1);
        req = 4'b0101;
        offer_word(64'h5555_6666_7777_8888, 4'b0001, "to_next");
        ack = 4'b0001;
        step(1);
        ack = '0;
        chk("to_next_served", {48'd0, served_cnt}, 64'd6);

        // Withdraw: requester 1 drops its request, requester 2 gets the same word.
        req = 4'b0110;
        offer_word(64'h9999_AAAA_BBBB_CCCC, 4'b0010, "wd");
        req = 4'b0100;
        step(1);
        chk("wd_grant_zero", {60'd0, grant}, 64'd0);
        chk("wd_valid_zero", {63'd0, out_valid}, 64'd0);
        step(1);
        chk("wd_regrant", {60'd0, grant}, 64'b0100);
        chk("wd_same_word", out_data, 64'h9999_AAAA_BBBB_CCCC);
        chk("wd_drop_same", {48'd0, drop_cnt}, 64'd1);
        ack = 4'b0100;
        step(1);
        ack = '0;
        chk("wd_served", {48'd0, served_cnt}, 64'd7);

        // Alarm while offering: word dropped, lockout entered.
        req = 4'b0001;
        offer_word(64'hDDDD_EEEE_FFFF_0000, 4'b0001, "al");
        health_alarm = 1'b1;
        step(1);
        health_alarm = 1'b0;
        chk("al_locked", {63'd0, locked}, 64'd1);
        chk("al_valid", {63'd0, out_valid}, 64'd0);
        chk("al_data", out_data, 64'd0);
        chk("al_grant", {60'd0, grant}, 64'd0);
        chk("al_drop", {48'd0, drop_cnt}, 64'd2);

        // An alarm pulse mid-recovery restarts the count.
        step(600);
        health_alarm = 1'b1;
        step(1);
        health_alarm = 1'b0;
        step(1023);
        chk("al_restart_locked", {63'd0, locked}, 64'd1);
        step(1);
        chk("al_restart_free", {63'd0, locked}, 64'd0);
        chk("al_restart_ready", {63'd0, src_ready}, 64'd1);

        // Ack coinciding with alarm still completes the transfer.
        offer_word(64'h1357_9BDF_2468_ACE0, 4'b0001, "alack");
        ack          = 4'b0001;
        health_alarm = 1'b1;
        step(1);
        ack          = '0;
        health_alarm = 1'b0;
        chk("alack_served", {48'd0, served_cnt}, 64'd8);
        chk("alack_drop", {48'd0, drop_cnt}, 64'd2);
        chk("alack_locked", {63'd0, locked}, 64'd1);
        step(1024);
        chk("alack_free", {63'd0, locked}, 64'd0);

        // Alarm on the capture cycle discards the incoming word.
        src_data     = 64'hCAFE_F00D_CAFE_F00D;
        src_valid    = 1'b1;
        health_alarm = 1'b1;
        step(1);
        src_valid    = 1'b0;
        health_alarm = 1'b0;
        chk("alcap_locked", {63'd0, locked}, 64'd1);
        chk("alcap_drop", {48'd0, drop_cnt}, 64'd3);
        step(1024);
        chk("alcap_free", {63'd0, src_ready}, 64'd1);

        // Saturation: preload served count near the top instead of 65k real transfers.
        force dut.served_q = 16'hFFFD;
        step(1);
        release dut.served_q;
        step(1);
        chk("sat_preload", {48'd0, served_cnt}, 64'hFFFD);
        offer_word(64'h0000_0000_0000_00A1, 4'b0001, "sat1");
        ack = 4'b1000;
        step(1);
        chk("bogus_ack_grant", {60'd0, grant}, 64'b0001);
        chk("bogus_ack_valid", {63'd0, out_valid}, 64'd1);
        chk("bogus_ack_served", {48'd0, served_cnt}, 64'hFFFD);
        ack = 4'b0001;
        step(1);
        ack = '0;
        chk("sat_fffe", {48'd0, served_cnt}, 64'hFFFE);
        offer_word(64'h0000_0000_0000_00A2, 4'b0001, "sat2");
        ack = 4'b0001;
        step(1);
        ack = '0;
        chk("sat_ffff", {48'd0, served_cnt}, 64'hFFFF);
        offer_word(64'h0000_0000_0000_00A3, 4'b0001, "sat3");
        ack = 4'b0001;
        step(1);
        ack = '0;
        chk("sat_hold", {48'd0, served_cnt}, 64'hFFFF);

        // Async reset while offering clears the grant without a clock edge.
        offer_word(64'h0000_0000_0000_00B0, 4'b0001, "arst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", {60'd0, grant}, 64'd0);
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_locked", {63'd0, locked}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
